pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Parametrised pipeline stage register with valid/ready handshake, stall, flush and optional
//  2-entry skid buffer; next generation of the fixed EXE->MEM latch. One instance per stage
//  boundary (IF/ID, ID/EXE, EXE/MEM, MEM/WB); a stalled stage back-pressures upstream without
//  losing data, and a flush turns the stage into a bubble whose control bits read as NOP.
// PARAMETERS
//  W         73        payload width (EXE/MEM: alu32 + b32 + rn5 + wreg,m2reg,wmem,z)
//  CTRL_MASK 73'hF     payload bits forced to 0 whenever out_valid=0 (write enables, etc.)
//  SKID      1         1: registered in_ready + 2-entry skid; 0: single entry, comb. in_ready
//  CNT_W     16        width of flush-drop statistics counter
// PORTS
//  clk        in   1      clock, all state updates on posedge
//  clrn       in   1      reset, synchronous, active-low
//  in_valid   in   1      upstream payload valid
//  in_ready   out  1      stage can accept; transfer ("in fire") = in_valid & in_ready
//  in_data    in   W      upstream payload
//  flush      in   1      synchronous kill of all held entries and of this cycle's input
//  out_valid  out  1      payload held for downstream
//  out_ready  in   1      downstream accepts; "out fire" = out_valid & out_ready
//  out_data   out  W      head payload; CTRL_MASK bits zeroed when out_valid=0
//  occ        out  2      entries held (0..2; max 1 when SKID=0)
//  drop_cnt   out  CNT_W  saturating count of valid entries discarded by flush
// BEHAVIOUR
//  - Reset (clrn=0 at posedge clk): state EMPTY, main=0, skid=0, drop_cnt=0; out_valid=0,
//    occ=0, out_data=0. in_ready=0 while clrn=0 (comb. gated). Reset wins over flush.
//  - Latency: 1 cycle in_fire -> out_valid. Order strictly FIFO; no duplication, no loss.
//  - States: EMPTY(occ0), FULL(occ1, main valid), SKIDF(occ2, main+skid valid; SKID=1 only).
//  - EMPTY: in fire -> FULL, main<=in_data.
//  - FULL: in&out fire -> FULL, main<=in_data; out only -> EMPTY; in only -> SKIDF,
//    skid<=in_data (SKID=1); neither -> hold.
//  - SKIDF: in_ready=0; out fire -> FULL, main<=skid; else hold.
//  - in_ready: SKID=1 -> registered, =(next state != SKIDF), no comb. path from out_ready;
//    SKID=0 -> (state==EMPTY) | out_ready (comb.), SKIDF unreachable.
//  - flush=1 (clrn=1): next state EMPTY regardless of fires; this cycle's input dropped even
//    if in fire; out fire in same cycle still counts as delivered (downstream took it).
//    drop_cnt += occ minus (1 if out fire); saturates at all-ones, never wraps.
//  - out_data = main when out_valid, else main & ~CTRL_MASK (bubble reads as NOP to consumers
//    that ignore out_valid). main/skid not cleared on pop; only masking applies.
//  - in_valid with in_ready=0: upstream must hold in_data stable; block does not sample it.
// STRUCTURE
//  - Package pipe_pkg: state enum {EMPTY,FULL,SKIDF}; per-stage payload field offsets/widths
//    and CTRL_MASK constants (EXE_MEM_W=73, EXE_MEM_CTRL_MASK, etc.).
//  - One sub-module: sat_counter (CNT_W, increment 0..2, sync active-low clear) for drop_cnt.
//  - Datapath: two W-bit registers (main, skid) + 2-bit state; skid omitted when SKID=0.
// TESTING
//  - Reset: clrn=0 two cycles with in_valid=1, data=73'h1_2345 -> out_valid=0, out_data=0,
//    in_ready=0, drop_cnt=0; release -> in_ready=1 next cycle.
//  - Streaming: out_ready=1, push A,B,C back-to-back -> out A,B,C one cycle later each, occ=1.
//  - Stall SKID=1: out_ready=0, push A,B -> occ=2, in_ready=0; C held stable; out_ready=1 ->
//    A,B,C emerge in order, no loss. SKID=0: B accepted only in cycle out_ready=1.
//  - Flush at occ=2, out_ready=0, in fire D -> next occ=0, out_valid=0, drop_cnt+=2,
//    D never appears; out_data[3:0]=0.
//  - Flush with out fire at occ=1 -> drop_cnt unchanged; preload drop_cnt to 16'hFFFF ->
//    further flushes keep FFFF.
//  - Random valid/ready/flush 10k cycles vs scoreboard: order, counts, occ, masking match.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and per-stage payload layouts for the pipeline stage registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKIDF = 2'd2
  } state_t;

  // IF/ID: pc32 + inst32, no control bits to squash
  localparam int          IF_ID_W          = 64;
  localparam logic [63:0] IF_ID_CTRL_MASK  = 64'h0;

  // EXE/MEM: {alu32, b32, rn5, wreg, m2reg, wmem, z}
  localparam int EXE_MEM_W       = 73;
  localparam int EXE_MEM_Z_OFS   = 0;
  localparam int EXE_MEM_WMEM    = 1;
  localparam int EXE_MEM_M2REG   = 2;
  localparam int EXE_MEM_WREG    = 3;
  localparam int EXE_MEM_RN_OFS  = 4;
  localparam int EXE_MEM_RN_W    = 5;
  localparam int EXE_MEM_B_OFS   = 9;
  localparam int EXE_MEM_ALU_OFS = 41;
  localparam logic [72:0] EXE_MEM_CTRL_MASK = 73'hF;

  // MEM/WB: {alu32, mem32, rn5, wreg, m2reg}
  localparam int          MEM_WB_W         = 71;
  localparam logic [70:0] MEM_WB_CTRL_MASK = 71'h3;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Upstream/downstream valid-ready handshake of one stage boundary.
interface pipe_stage_reg_if
  import pipe_pkg::*;
#(
  parameter int W = EXE_MEM_W
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;

  // master: the surrounding pipeline (producer upstream, consumer downstream)
  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data);
  // slave: the stage register itself
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data);
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter, step 0..2 per cycle, synchronous active-low clear.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [1:0]       inc,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W:0] sum;

  assign sum = {1'b0, cnt} + (CNT_W+1)'(inc);

  // clamp at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (!clrn)            cnt <= '0;
    else if (sum[CNT_W])  cnt <= '1;
    else                  cnt <= sum[CNT_W-1:0];
  end
endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: valid/ready, flush-to-bubble, optional 2-entry skid.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int           W         = EXE_MEM_W,
  parameter logic [W-1:0] CTRL_MASK = W'(EXE_MEM_CTRL_MASK),
  parameter bit           SKID      = 1'b1,
  parameter int           CNT_W     = 16
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             flush,
  pipe_stage_reg_if.slave  bus,
  output logic [1:0]       occ,
  output logic [CNT_W-1:0] drop_cnt
);
  state_t       state, nstate;
  logic [W-1:0] main, skid;
  logic         in_fire, out_fire;
  logic         ld_main, main_from_skid, ld_skid;
  logic [1:0]   drop_inc;

  assign in_fire  = bus.in_valid & bus.in_ready;
  assign out_fire = bus.out_valid & bus.out_ready;

  assign bus.out_valid = (state != EMPTY);
  assign occ           = (state == EMPTY) ? 2'd0 : (state == FULL) ? 2'd1 : 2'd2;
  // bubbles keep the datapath bits but read as NOP on the control bits
  assign bus.out_data  = bus.out_valid ? main : (main & ~CTRL_MASK);

  // next state and register load enables; flush overrides everything
  always_comb begin
    nstate         = state;
    ld_main        = 1'b0;
    main_from_skid = 1'b0;
    ld_skid        = 1'b0;
    unique case (state)
      EMPTY: if (in_fire) begin nstate = FULL; ld_main = 1'b1; end
      FULL: begin
        if (in_fire && out_fire)  ld_main = 1'b1;
        else if (out_fire)        nstate = EMPTY;
        else if (in_fire && SKID) begin nstate = SKIDF; ld_skid = 1'b1; end
      end
      SKIDF: if (out_fire) begin nstate = FULL; ld_main = 1'b1; main_from_skid = 1'b1; end
      default: nstate = EMPTY;
    endcase
    if (flush) begin
      nstate  = EMPTY;
      ld_main = 1'b0;
      ld_skid = 1'b0;
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (!clrn) state <= EMPTY;
    else       state <= nstate;
  end

  // head entry; not cleared on pop, only masked at the output
  always_ff @(posedge clk) begin
    if (!clrn)        main <= '0;
    else if (ld_main) main <= main_from_skid ? skid : bus.in_data;
  end

  generate
    if (SKID) begin : g_skid
      logic rdy_q;
      // second entry catches the word accepted while downstream stalled
      always_ff @(posedge clk) begin
        if (!clrn)        skid <= '0;
        else if (ld_skid) skid <= bus.in_data;
      end
      // registered ready: no combinational path from out_ready
      always_ff @(posedge clk) begin
        if (!clrn) rdy_q <= 1'b0;
        else       rdy_q <= (nstate != SKIDF);
      end
      assign bus.in_ready = clrn & rdy_q;
    end else begin : g_noskid
      assign skid         = '0;
      assign bus.in_ready = clrn & ((state == EMPTY) | bus.out_ready);
    end
  endgenerate

  // entries lost to flush: everything held except what downstream took this cycle
  assign drop_inc = flush ? (occ - {1'b0, out_fire}) : 2'd0;

  sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
    .clk  (clk),
    .clrn (clrn),
    .inc  (drop_inc),
    .cnt  (drop_cnt)
  );
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench: SKID=1 and SKID=0 stages driven in lockstep against a queue model.
module tb_pipe_stage_reg;
  localparam int           W     = 73;
  localparam int           CNT_W = 4;
  localparam int           CMAX  = (1 << CNT_W) - 1;
  localparam logic [W-1:0] MASK  = 73'hF;

  logic             clk = 1'b0;
  logic             clrn, flush;
  logic [1:0]       occ1, occ0;
  logic [CNT_W-1:0] cnt1, cnt0;

  pipe_stage_reg_if #(.W(W)) b1 ();
  pipe_stage_reg_if #(.W(W)) b0 ();

  pipe_stage_reg #(.W(W), .CTRL_MASK(MASK), .SKID(1'b1), .CNT_W(CNT_W)) dut1 (
    .clk(clk), .clrn(clrn), .flush(flush), .bus(b1), .occ(occ1), .drop_cnt(cnt1));
  pipe_stage_reg #(.W(W), .CTRL_MASK(MASK), .SKID(1'b0), .CNT_W(CNT_W)) dut0 (
    .clk(clk), .clrn(clrn), .flush(flush), .bus(b0), .occ(occ0), .drop_cnt(cnt0));

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // reference model: a FIFO per DUT plus the last head word and drop total
  logic [W-1:0] mq [2][$];
  logic [W-1:0] last [2];
  int           mcnt [2];
  bit           rok [2];
  bit           init = 1'b0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // one clock: drive at negedge, check outputs against model, advance model at posedge
  task automatic cyc(input bit rn, input bit iv, input logic [W-1:0] d, input bit orr, input bit fl);
    bit er [2];
    int n;
    @(negedge clk);
    clrn = rn; flush = fl;
    b1.in_valid = iv; b1.in_data = d; b1.out_ready = orr;
    b0.in_valid = iv; b0.in_data = d; b0.out_ready = orr;
    #1;
    for (int k = 0; k < 2; k++) begin
      n = mq[k].size();
      er[k] = rn && ((k == 1) ? (rok[k] && n < 2) : (n == 0 || orr));
      if (init) begin
        chk($sformatf("s%0d_out_valid", k), W'(k ? b1.out_valid : b0.out_valid), W'(n > 0));
        chk($sformatf("s%0d_out_data", k), k ? b1.out_data : b0.out_data,
            (n > 0) ? mq[k][0] : (last[k] & ~MASK));
        chk($sformatf("s%0d_in_ready", k), W'(k ? b1.in_ready : b0.in_ready), W'(er[k]));
        chk($sformatf("s%0d_occ", k), W'(k ? occ1 : occ0), W'(n));
        chk($sformatf("s%0d_drop_cnt", k), W'(k ? cnt1 : cnt0), W'(mcnt[k]));
      end
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!rn) begin
        mq[k].delete(); last[k] = '0; mcnt[k] = 0; rok[k] = 1'b0;
      end else begin
        bit infire, outfire;
        n = mq[k].size();
        infire  = iv && er[k];
        outfire = (n > 0) && orr;
        if (fl) begin
          mcnt[k] = mcnt[k] + n - int'(outfire);
          if (mcnt[k] > CMAX) mcnt[k] = CMAX;
          mq[k].delete();
        end else begin
          if (outfire) void'(mq[k].pop_front());
          if (infire)  mq[k].push_back(d);
        end
        rok[k] = 1'b1;
        if (mq[k].size() > 0) last[k] = mq[k][0];
      end
    end
    if (!rn) init = 1'b1;
  endtask

  function automatic logic [W-1:0] rnd();
    return W'({$urandom, $urandom, $urandom});
  endfunction

  logic [W-1:0] va, vb, vc, lv;

  initial begin
    clrn = 1'b0; flush = 1'b0;
    b1.in_valid = 1'b0; b1.in_data = '0; b1.out_ready = 1'b0;
    b0.in_valid = 1'b0; b0.in_data = '0; b0.out_ready = 1'b0;

    // reset with upstream asserting valid
    cyc(0, 1, 73'h1_2345, 0, 0);
    cyc(0, 1, 73'h1_2345, 0, 0);
    #1;
    chk("rst_out_valid", W'(b1.out_valid), '0);
    chk("rst_out_data",  b1.out_data, '0);
    chk("rst_in_ready",  W'(b1.in_ready), '0);
    chk("rst_drop_cnt",  W'(cnt1), '0);
    cyc(1, 0, '0, 1, 0);
    #1;
    chk("release_in_ready", W'(b1.in_ready), W'(1));

    // streaming back-to-back
    va = rnd(); vb = rnd(); vc = rnd();
    cyc(1, 1, va, 1, 0);
    #1;
    chk("stream_first", b1.out_data, va);
    chk("stream_occ", W'(occ1), W'(1));
    cyc(1, 1, vb, 1, 0);
    cyc(1, 1, vc, 1, 0);
    cyc(1, 0, '0, 1, 0);
    cyc(1, 0, '0, 1, 0);

    // stall: two words held, third waits, then drain in order
    va = rnd(); vb = rnd(); vc = rnd();
    cyc(1, 1, va, 0, 0);
    cyc(1, 1, vb, 0, 0);
    #1;
    chk("stall_occ", W'(occ1), W'(2));
    chk("stall_in_ready", W'(b1.in_ready), '0);
    cyc(1, 1, vc, 0, 0);
    cyc(1, 1, vc, 1, 0);
    cyc(1, 1, vc, 1, 0);
    cyc(1, 0, '0, 1, 0);
    cyc(1, 0, '0, 1, 0);
    cyc(1, 0, '0, 1, 0);

    // flush at occ=2 while a new word fires
    cyc(0, 0, '0, 0, 0);
    cyc(1, 0, '0, 0, 0);
    cyc(1, 1, rnd(), 0, 0);
    cyc(1, 1, rnd(), 0, 0);
    cyc(1, 1, 73'h1_FFFF_FFFF, 0, 1);
    #1;
    lv = b1.out_data;
    chk("flush_occ", W'(occ1), '0);
    chk("flush_out_valid", W'(b1.out_valid), '0);
    chk("flush_drop", W'(cnt1), W'(2));
    chk("flush_ctrl_bits", W'(lv[3:0]), '0);
    cyc(1, 0, '0, 1, 0);

    // flush while downstream takes the only entry: nothing dropped
    cyc(1, 1, rnd(), 1, 0);
    cyc(1, 0, '0, 1, 1);
    #1;
    chk("flush_outfire_drop", W'(cnt1), W'(2));

    // drive drop_cnt into saturation and keep flushing
    for (int i = 0; i < 9; i++) begin
      cyc(1, 1, rnd(), 0, 0);
      cyc(1, 1, rnd(), 0, 0);
      cyc(1, 0, '0, 0, 1);
    end
    #1;
    chk("sat_drop", W'(cnt1), W'(CMAX));
    cyc(1, 1, rnd(), 0, 0);
    cyc(1, 1, rnd(), 0, 0);
    cyc(1, 0, '0, 0, 1);
    #1;
    chk("sat_hold", W'(cnt1), W'(CMAX));

    // randomized valid/ready/flush with rare resets
    for (int i = 0; i < 10000; i++) begin
      cyc(($urandom_range(0, 499) != 0), ($urandom_range(0, 3) != 0), rnd(),
          ($urandom_range(0, 2) != 0), ($urandom_range(0, 39) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
